// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package divider_pkg;

   // Controller states: waiting for operands, or iterating.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } t_div_state;

   localparam int DEFAULT_DATA_LEN       = 32;
   localparam int DEFAULT_BITS_PER_CYCLE = 8;

   // Number of iteration cycles needed to resolve every quotient bit.
   function automatic int div_iters(input int data_len, input int bits_per_cycle);
      return data_len / bits_per_cycle;
   endfunction

   // Counter width able to hold the value N (not just N-1).
   function automatic int div_cnt_width(input int iters);
      return (iters < 1) ? 1 : $clog2(iters + 1);
   endfunction

endpackage

// File: rtl/divider_step.sv
// One iteration of the divider: BITS_PER_CYCLE chained restoring stages.
// Purely combinational. The partial remainder entering a stage is always
// smaller than the divisor, so after the left shift it fits in DATA_LEN+1
// bits; the trial subtraction is done at that width and its top bit is the
// borrow.
module divider_step
   import divider_pkg::*;
#(
   parameter int DATA_LEN       = DEFAULT_DATA_LEN,
   parameter int BITS_PER_CYCLE = DEFAULT_BITS_PER_CYCLE
) (
   input  logic [DATA_LEN-1:0]       rem_in,
   input  logic [BITS_PER_CYCLE-1:0] dividend_bits,
   input  logic [DATA_LEN-1:0]       divisor,
   output logic [DATA_LEN-1:0]       rem_out,
   output logic [BITS_PER_CYCLE-1:0] quot_bits
);

   logic [DATA_LEN:0]   shifted;
   logic [DATA_LEN:0]   diff;
   logic [DATA_LEN-1:0] rem;

   // Chain of restoring stages, most significant dividend bit first.
   always_comb begin
      shifted   = '0;
      diff      = '0;
      rem       = rem_in;
      quot_bits = '0;
      for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
         shifted = {rem, dividend_bits[i]};
         diff    = shifted - {1'b0, divisor};
         if (!diff[DATA_LEN]) begin
            // No borrow: divisor fits, keep the difference.
            rem          = diff[DATA_LEN-1:0];
            quot_bits[i] = 1'b1;
         end else begin
            // Borrow: restore the shifted remainder.
            rem          = shifted[DATA_LEN-1:0];
            quot_bits[i] = 1'b0;
         end
      end
      rem_out = rem;
   end

endmodule

// File: rtl/divider.sv
// Unsigned iterative restoring divider, BITS_PER_CYCLE quotient bits per
// clock. A start is inferred from non-zero operands seen in IDLE; the
// quotient appears on `result` after the capture edge plus N iteration
// edges (N = DATA_LEN/BITS_PER_CYCLE) and is held until the next operation.
//
// Handshake: there is none. The host pulses a/b for one cycle (zeros
// otherwise) and samples result a fixed latency later. Operands presented
// while RUN are ignored; the edge that returns to IDLE never starts.
//
// Build option: define DIVIDER_DIV0_SAT_EN to make divide-by-zero return
// all ones; otherwise it returns zero. Timing is the same either way.
module divider
   import divider_pkg::*;
#(
   parameter int DATA_LEN       = DEFAULT_DATA_LEN,
   parameter int BITS_PER_CYCLE = DEFAULT_BITS_PER_CYCLE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_LEN-1:0] a,
   input  logic [DATA_LEN-1:0] b,
   output logic [DATA_LEN-1:0] result
);

   localparam int ITERS = div_iters(DATA_LEN, BITS_PER_CYCLE);
   localparam int CNT_W = div_cnt_width(ITERS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

`ifdef DIVIDER_DIV0_SAT_EN
   localparam logic [DATA_LEN-1:0] DIV0_VALUE = {DATA_LEN{1'b1}};
`else
   localparam logic [DATA_LEN-1:0] DIV0_VALUE = '0;
`endif

   generate
      if ((BITS_PER_CYCLE < 1) || (DATA_LEN % BITS_PER_CYCLE != 0)) begin : g_bad_cfg
         $error("divider: DATA_LEN (%0d) must be a multiple of BITS_PER_CYCLE (%0d)",
                DATA_LEN, BITS_PER_CYCLE);
      end
   endgenerate

   // Controller state, kept as a plain named signal for hierarchical probing.
   t_div_state state;
   t_div_state next_state;

   // Control strobes decoded from the state.
   logic start;
   logic iterate;
   logic finish;

   // Datapath registers.
   logic [DATA_LEN-1:0] dividend_q;
   logic [DATA_LEN-1:0] divisor_q;
   logic [DATA_LEN-1:0] rem_q;
   logic [DATA_LEN-1:0] quot_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                div0_q;

   // Step outputs and assembled quotient for this cycle.
   logic [DATA_LEN-1:0]       rem_next;
   logic [BITS_PER_CYCLE-1:0] quot_bits;
   logic [DATA_LEN-1:0]       quot_next;

   divider_step #(
      .DATA_LEN       (DATA_LEN),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .rem_in        (rem_q),
      .dividend_bits (dividend_q[DATA_LEN-1 -: BITS_PER_CYCLE]),
      .divisor       (divisor_q),
      .rem_out       (rem_next),
      .quot_bits     (quot_bits)
   );

   // New quotient bits enter at the bottom as earlier bits move up.
   always_comb begin
      quot_next = (quot_q << BITS_PER_CYCLE) | DATA_LEN'(quot_bits);
   end

   // State register; reset aborts any division in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and control strobes.
   always_comb begin
      next_state = state;
      start      = 1'b0;
      iterate    = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if ((a | b) != '0) begin
               start      = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            iterate = 1'b1;
            if (cnt_q == CNT_LAST) begin
               finish     = 1'b1;
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Operand capture, iteration registers and the held result.
   always_ff @(posedge clk) begin
      if (reset) begin
         dividend_q <= '0;
         divisor_q  <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         cnt_q      <= '0;
         div0_q     <= 1'b0;
         result     <= '0;
      end else if (start) begin
         dividend_q <= a;
         divisor_q  <= b;
         rem_q      <= '0;
         quot_q     <= '0;
         cnt_q      <= CNT_LOAD;
         div0_q     <= (b == '0);
      end else if (iterate) begin
         dividend_q <= dividend_q << BITS_PER_CYCLE;
         rem_q      <= rem_next;
         quot_q     <= quot_next;
         cnt_q      <= cnt_q - CNT_LAST;
         if (finish) begin
            result <= div0_q ? DIV0_VALUE : quot_next;
         end
      end
   end

endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: fixed-latency pulses, held-result checks,
// inputs ignored while busy, reset abort, and divide-by-zero.
module tb_divider;
   import divider_pkg::*;

   localparam int W = 32;

`ifdef DIVIDER_DIV0_SAT_EN
   localparam logic [W-1:0] DIV0_EXP = 32'hFFFF_FFFF;
`else
   localparam logic [W-1:0] DIV0_EXP = 32'h0000_0000;
`endif

   logic         clk;
   logic         reset;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] result;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_res;

   divider dut (
      .clk    (clk),
      .reset  (reset),
      .a      (a),
      .b      (b),
      .result (result)
   );

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Pulse one operation and check both the pre-completion hold and the result.
   task automatic run_div(input string tag, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] exp);
      logic [W-1:0] e;
      exp_q.push_back(exp);
      @(negedge clk);
      a = av;
      b = bv;
      @(posedge clk);          // edge 1: capture
      #1;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1;                      // after edge 4: old value still held
      check({tag, "_hold_pre"}, result, last_res);
      @(posedge clk);          // edge 5: result written
      #1;
      e = exp_q.pop_front();
      check(tag, result, e);
      last_res = e;
   endtask

   initial begin
      reset    = 1'b1;
      a        = '0;
      b        = '0;
      last_res = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_result", result, '0);
      check("rst_state", W'(dut.state), W'(IDLE));
      @(negedge clk);
      reset = 1'b0;

      // Basic division and hold.
      run_div("div_100_7", 32'd100, 32'd7, 32'd14);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         check("hold_14", result, 32'd14);
      end

      run_div("div_max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
      run_div("div_5_10", 32'd5, 32'd10, 32'd0);
      run_div("div_1000_1000", 32'd1000, 32'd1000, 32'd1);
      run_div("div_42_0", 32'd42, 32'd0, DIV0_EXP);

      // Operands presented mid-run must be ignored.
      @(negedge clk);
      a = 32'd100;
      b = 32'd7;
      @(posedge clk);          // edge 1
      #1;
      a = '0;
      b = '0;
      @(posedge clk);          // edge 2
      #1;
      a = 32'd50;
      b = 32'd5;
      @(posedge clk);          // edge 3
      #1;
      a = '0;
      b = '0;
      @(posedge clk);          // edge 4
      #1;
      check("busy_hold_pre", result, last_res);
      @(posedge clk);          // edge 5
      #1;
      check("busy_ignore", result, 32'd14);
      last_res = 32'd14;
      run_div("div_50_5", 32'd50, 32'd5, 32'd10);

      // Reset in the middle of a division.
      @(negedge clk);
      a = 32'd100;
      b = 32'd7;
      @(posedge clk);          // edge 1
      #1;
      a = '0;
      b = '0;
      @(posedge clk);          // edge 2
      #1;
      reset = 1'b1;
      @(posedge clk);          // edge 3 with reset
      #1;
      reset = 1'b0;
      check("abort_result", result, '0);
      check("abort_state", W'(dut.state), W'(IDLE));
      last_res = '0;
      run_div("div_9_3", 32'd9, 32'd3, 32'd3);

      // Zero operands in IDLE do not start anything.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         check("idle_zero_result", result, 32'd3);
      end
      check("idle_zero_state", W'(dut.state), W'(IDLE));

      // Wide-divisor and assorted patterns.
      run_div("div_max_msb", 32'hFFFF_FFFF, 32'h8000_0000, 32'd1);
      run_div("div_deadbeef", 32'hDEAD_BEEF, 32'h0000_1234, 32'd801701);
      run_div("div_fffe_ffff", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0);
      run_div("div_7_7", 32'd7, 32'd7, 32'd1);
      run_div("div_0_5", 32'd0, 32'd5, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
